// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared state type, ID/payload widths and response codes for the AXI read arbiter
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
package axi_arb_pkg;
    localparam int MSEL_BITS = `AXI_IDS_BITS - `AXI_ID_BITS;
    localparam int ADDR_BITS = 32;
    localparam int DATA_BITS = 32;
    localparam int LEN_BITS  = 8;
    localparam int SIZE_BITS = 3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
endpackage

// File: rtl/axi_read_arbiter_rr_picker.sv
// rr_picker: picks the next master to serve; round-robin by default, fixed lowest-index priority with AXI_ARB_FIXED_PRIO_EN
module rr_picker #(
    parameter int N  = 2,
    parameter int GW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    input  logic          update,
    input  logic [GW-1:0] grant,
    output logic [GW-1:0] pick
);
`ifdef AXI_ARB_FIXED_PRIO_EN
    logic unused_hist;
    assign unused_hist = ^{clk, rstn, update, grant};
    // lowest requesting index wins, no history kept
    always_comb begin
        pick = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) pick = GW'(i);
    end
`else
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] idx;
    logic          found;
    // start the next search one past the master whose burst just completed
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) rr_ptr <= '0;
        else if (update) rr_ptr <= (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    // first requester at or after rr_ptr, wrapping modulo N
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = GW'((int'(rr_ptr) + i) % N);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: per-slave AR arbiter with R routing, one outstanding burst; AXI_ARB_FIXED_PRIO_EN selects fixed priority
module axi_read_arbiter import axi_arb_pkg::*; #(
    parameter int NUM_MASTERS = 2,
    parameter int MSEL_BITS   = axi_arb_pkg::MSEL_BITS
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic [NUM_MASTERS-1:0][`AXI_ID_BITS-1:0]    ARID_M,
    input  logic [NUM_MASTERS-1:0][ADDR_BITS-1:0]       ARADDR_M,
    input  logic [NUM_MASTERS-1:0][LEN_BITS-1:0]        ARLEN_M,
    input  logic [NUM_MASTERS-1:0][SIZE_BITS-1:0]       ARSIZE_M,
    input  logic [NUM_MASTERS-1:0][1:0]                 ARBURST_M,
    input  logic [NUM_MASTERS-1:0]                      ARVALID_M,
    output logic [NUM_MASTERS-1:0]                      ARREADY_M,
    output logic [`AXI_ID_BITS-1:0]                     RID_M,
    output logic [DATA_BITS-1:0]                        RDATA_M,
    output logic [1:0]                                  RRESP_M,
    output logic                                        RLAST_M,
    output logic [NUM_MASTERS-1:0]                      RVALID_M,
    input  logic [NUM_MASTERS-1:0]                      RREADY_M,
    output logic [`AXI_IDS_BITS-1:0]                    ARID_S,
    output logic [ADDR_BITS-1:0]                        ARADDR_S,
    output logic [LEN_BITS-1:0]                         ARLEN_S,
    output logic [SIZE_BITS-1:0]                        ARSIZE_S,
    output logic [1:0]                                  ARBURST_S,
    output logic                                        ARVALID_S,
    input  logic                                        ARREADY_S,
    input  logic [`AXI_IDS_BITS-1:0]                    RID_S,
    input  logic [DATA_BITS-1:0]                        RDATA_S,
    input  logic [1:0]                                  RRESP_S,
    input  logic                                        RLAST_S,
    input  logic                                        RVALID_S,
    output logic                                        RREADY_S
);
    localparam int GW = $clog2(NUM_MASTERS);
    state_t        state, next_state;
    logic [GW-1:0] grant, pick;
    logic          done;
    logic          unused_rid;
    assign unused_rid = ^RID_S[`AXI_IDS_BITS-1:`AXI_ID_BITS];
    assign done = (state == DATA) && RVALID_S && RREADY_M[grant] && RLAST_S;
    rr_picker #(.N(NUM_MASTERS), .GW(GW)) u_pick (
        .clk    (clk),
        .rstn   (rstn),
        .req    (ARVALID_M),
        .update (done),
        .grant  (grant),
        .pick   (pick)
    );
    // state and grant registers; grant is latched only when leaving IDLE
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && |ARVALID_M) grant <= pick;
        end
    // next state and all channel outputs; payloads are zero outside their owning state
    always_comb begin
        next_state = state;
        ARREADY_M  = '0;
        ARVALID_S  = 1'b0;
        ARID_S     = '0;
        ARADDR_S   = '0;
        ARLEN_S    = '0;
        ARSIZE_S   = '0;
        ARBURST_S  = '0;
        RVALID_M   = '0;
        RREADY_S   = 1'b0;
        RID_M      = '0;
        RDATA_M    = '0;
        RRESP_M    = '0;
        RLAST_M    = 1'b0;
        case (state)
            IDLE: if (|ARVALID_M) next_state = ADDR;
            ADDR: begin
                ARVALID_S        = ARVALID_M[grant];
                ARREADY_M[grant] = ARREADY_S;
                ARID_S           = {MSEL_BITS'(grant), ARID_M[grant]};
                ARADDR_S         = ARADDR_M[grant];
                ARLEN_S          = ARLEN_M[grant];
                ARSIZE_S         = ARSIZE_M[grant];
                ARBURST_S        = ARBURST_M[grant];
                if (ARVALID_M[grant] && ARREADY_S) next_state = DATA;
            end
            DATA: begin
                RVALID_M[grant] = RVALID_S;
                RREADY_S        = RREADY_M[grant];
                RID_M           = RID_S[`AXI_ID_BITS-1:0];
                RDATA_M         = RDATA_S;
                RRESP_M         = RRESP_S;
                RLAST_M         = RLAST_S;
                if (done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: table-driven and sequence checks of the AXI read arbiter with two masters
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
module tb_axi_read_arbiter;
    logic             clk = 1'b0;
    logic             rstn;
    logic [1:0][3:0]  arid_m;
    logic [1:0][31:0] araddr_m;
    logic [1:0][7:0]  arlen_m;
    logic [1:0][2:0]  arsize_m;
    logic [1:0][1:0]  arburst_m;
    logic [1:0]       ARVALID_M, ARREADY_M, RVALID_M, RREADY_M;
    logic [3:0]       RID_M;
    logic [31:0]      RDATA_M, ARADDR_S, RDATA_S;
    logic [1:0]       RRESP_M, ARBURST_S, RRESP_S;
    logic             RLAST_M, ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;
    logic [7:0]       ARID_S, ARLEN_S, RID_S;
    logic [2:0]       ARSIZE_S;
    int               n_chk = 0;
    int               n_fail = 0;

    axi_read_arbiter #(.NUM_MASTERS(2)) dut (
        .clk(clk), .rstn(rstn),
        .ARID_M(arid_m), .ARADDR_M(araddr_m), .ARLEN_M(arlen_m), .ARSIZE_M(arsize_m),
        .ARBURST_M(arburst_m), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
    );

    always #5 clk = ~clk;

    logic [97:0] all_out;
    assign all_out = {ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
                      ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S};
    logic [49:0] got;
    assign got = {ARVALID_S, ARREADY_M, RVALID_M, RREADY_S, ARID_S, RID_M, ARADDR_S};

`ifdef AXI_ARB_FIXED_PRIO_EN
    localparam logic [1:0]  G2 = 2'b01;
    localparam logic [7:0]  A2 = 8'h05;
    localparam logic [31:0] D2 = 32'h2000;
    localparam logic [3:0]  R2 = 4'h5;
    localparam logic [5:0]  CSEQ = 6'b01_01_01;
`else
    localparam logic [1:0]  G2 = 2'b10;
    localparam logic [7:0]  A2 = 8'h13;
    localparam logic [31:0] D2 = 32'h1000;
    localparam logic [3:0]  R2 = 4'h3;
    localparam logic [5:0]  CSEQ = 6'b01_10_01;
`endif

    typedef struct {
        logic [1:0]  arv;
        logic        arr_s;
        logic        rv_s;
        logic        last_s;
        logic [1:0]  rr_m;
        logic [7:0]  rid_s;
        logic [49:0] exp;
    } vec_t;
    vec_t tbl[17];

    function automatic logic [49:0] mk(logic arvs, logic [1:0] arrm, logic [1:0] rvm, logic rrs,
                                       logic [7:0] arid, logic [3:0] rid, logic [31:0] addr);
        return {arvs, arrm, rvm, rrs, arid, rid, addr};
    endfunction

    task automatic chk(input string name, input logic [127:0] g, input logic [127:0] e);
        n_chk++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, g, e);
        end
    endtask

    task automatic idle_inputs();
        ARVALID_M = 2'b00; ARREADY_S = 1'b0; RVALID_S = 1'b0; RLAST_S = 1'b0;
        RREADY_M = 2'b00; RID_S = 8'h00; RDATA_S = 32'h0; RRESP_S = 2'b00;
    endtask

    task automatic burst(input logic [1:0] req, input int len, input int ar_wait, input bit toggle,
                         output logic [1:0] who, output int beats, output int lat, output bit stable);
        int n;
        bit fin;
        logic [47:0] snap;
        @(negedge clk);
        ARVALID_M = req; ARREADY_S = 1'b0; RVALID_S = 1'b0; RLAST_S = 1'b0; RREADY_M = 2'b11;
        #1;
        lat = 0;
        while (!ARVALID_S && lat < 8) begin @(negedge clk); #1; lat++; end
        stable = 1'b1;
        snap = {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S};
        for (int i = 0; i < ar_wait; i++) begin
            if ({ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} != snap || ARREADY_M != 2'b00 || !ARVALID_S)
                stable = 1'b0;
            @(negedge clk); #1;
        end
        if ({ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} != snap) stable = 1'b0;
        ARREADY_S = 1'b1;
        #1;
        who = ARREADY_M;
        @(negedge clk);
        ARREADY_S = 1'b0; RVALID_S = 1'b1;
        beats = 0; n = 0; fin = 1'b0;
        while (n < 60 && !fin) begin
            RREADY_M = (toggle && n[0]) ? 2'b00 : 2'b11;
            RLAST_S  = (beats == len);
            RDATA_S  = beats;
            #1;
            if (RVALID_M != 2'b00 && RREADY_S) begin
                beats++;
                if (RLAST_S) fin = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        RVALID_S = 1'b0; RLAST_S = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] who;
        int beats, lat;
        bit stable;
        arid_m    = {4'h3, 4'h5};
        araddr_m  = {32'h1000, 32'h2000};
        arlen_m   = {8'd3, 8'd0};
        arsize_m  = {3'd2, 3'd2};
        arburst_m = {2'b01, 2'b01};
        tbl[0]  = '{2'b10, 0, 0, 0, 2'b00, 8'h00, mk(0, 2'b00, 2'b00, 0, 8'h00, 4'h0, 32'h0)};
        tbl[1]  = '{2'b10, 0, 0, 0, 2'b00, 8'h00, mk(1, 2'b00, 2'b00, 0, 8'h13, 4'h0, 32'h1000)};
        tbl[2]  = '{2'b10, 1, 0, 0, 2'b00, 8'h00, mk(1, 2'b10, 2'b00, 0, 8'h13, 4'h0, 32'h1000)};
        tbl[3]  = '{2'b00, 0, 1, 0, 2'b10, 8'h13, mk(0, 2'b00, 2'b10, 1, 8'h00, 4'h3, 32'h0)};
        tbl[4]  = '{2'b00, 0, 1, 0, 2'b00, 8'h13, mk(0, 2'b00, 2'b10, 0, 8'h00, 4'h3, 32'h0)};
        tbl[5]  = '{2'b00, 0, 1, 0, 2'b10, 8'h13, mk(0, 2'b00, 2'b10, 1, 8'h00, 4'h3, 32'h0)};
        tbl[6]  = '{2'b00, 0, 0, 0, 2'b10, 8'h13, mk(0, 2'b00, 2'b00, 1, 8'h00, 4'h3, 32'h0)};
        tbl[7]  = '{2'b00, 0, 1, 0, 2'b10, 8'h13, mk(0, 2'b00, 2'b10, 1, 8'h00, 4'h3, 32'h0)};
        tbl[8]  = '{2'b00, 0, 1, 1, 2'b10, 8'h13, mk(0, 2'b00, 2'b10, 1, 8'h00, 4'h3, 32'h0)};
        tbl[9]  = '{2'b00, 0, 1, 0, 2'b11, 8'h13, mk(0, 2'b00, 2'b00, 0, 8'h00, 4'h0, 32'h0)};
        tbl[10] = '{2'b11, 0, 0, 0, 2'b00, 8'h00, mk(0, 2'b00, 2'b00, 0, 8'h00, 4'h0, 32'h0)};
        tbl[11] = '{2'b11, 1, 0, 0, 2'b00, 8'h00, mk(1, 2'b01, 2'b00, 0, 8'h05, 4'h0, 32'h2000)};
        tbl[12] = '{2'b11, 0, 1, 1, 2'b01, 8'h15, mk(0, 2'b00, 2'b01, 1, 8'h00, 4'h5, 32'h0)};
        tbl[13] = '{2'b11, 0, 0, 0, 2'b00, 8'h00, mk(0, 2'b00, 2'b00, 0, 8'h00, 4'h0, 32'h0)};
        tbl[14] = '{2'b11, 1, 0, 0, 2'b00, 8'h00, mk(1, G2, 2'b00, 0, A2, 4'h0, D2)};
        tbl[15] = '{2'b00, 0, 1, 1, G2, A2, mk(0, 2'b00, G2, 1, 8'h00, R2, 32'h0)};
        tbl[16] = '{2'b00, 0, 0, 0, 2'b00, 8'h00, mk(0, 2'b00, 2'b00, 0, 8'h00, 4'h0, 32'h0)};

        rstn = 1'b0;
        idle_inputs();
        ARVALID_M = 2'b11; RVALID_S = 1'b1; RREADY_M = 2'b11; RDATA_S = 32'hdead_beef;
        @(negedge clk); @(negedge clk); #1;
        chk("reset_outputs", 128'(all_out), 128'h0);
        idle_inputs();
        rstn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ARVALID_M = tbl[i].arv; ARREADY_S = tbl[i].arr_s; RVALID_S = tbl[i].rv_s;
            RLAST_S = tbl[i].last_s; RREADY_M = tbl[i].rr_m; RID_S = tbl[i].rid_s;
            #1;
            chk($sformatf("vec%0d", i), 128'(got), 128'(tbl[i].exp));
            @(negedge clk);
        end

        idle_inputs();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            burst(2'b11, 0, 0, 1'b0, who, beats, lat, stable);
            chk($sformatf("contention_grant%0d", k), 128'(who), 128'(CSEQ[5-2*k -: 2]));
        end
        ARVALID_M = 2'b00;
        @(negedge clk);

        arlen_m[0] = 8'd7;
        burst(2'b01, 7, 5, 1'b1, who, beats, lat, stable);
        ARVALID_M = 2'b00;
        chk("bp_grant", 128'(who), 128'(2'b01));
        chk("bp_latency", 128'(lat), 128'(1));
        chk("bp_ar_stable", 128'(stable), 128'(1));
        chk("bp_beats", 128'(beats), 128'(8));

        @(negedge clk);
        ARVALID_M = 2'b10; ARREADY_S = 1'b1; RREADY_M = 2'b11;
        @(negedge clk);
        @(negedge clk);
        ARVALID_M = 2'b00; ARREADY_S = 1'b0; RVALID_S = 1'b1; RLAST_S = 1'b0;
        #1;
        chk("mid_beat1", 128'({RVALID_M, RREADY_S}), 128'(3'b101));
        @(negedge clk); #1;
        chk("mid_beat2", 128'({RVALID_M, RREADY_S}), 128'(3'b101));
        #2;
        rstn = 1'b0;
        #1;
        chk("async_reset_outputs", 128'(all_out), 128'h0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post_reset_stray", 128'({RVALID_M, RREADY_S}), 128'h0);
        RVALID_S = 1'b0;
        burst(2'b10, 3, 0, 1'b0, who, beats, lat, stable);
        ARVALID_M = 2'b00;
        chk("post_reset_grant", 128'(who), 128'(2'b10));
        chk("post_reset_latency", 128'(lat), 128'(1));
        chk("post_reset_beats", 128'(beats), 128'(4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
